// File: rtl/systolic_pkg.sv
// Shared types and width helpers for the parametrised systolic matrix-multiply engine.
// Pure declarations: no logic, no latency, no flow control.
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Reduction-depth field must hold K_MAX itself, not just K_MAX-1.
    function automatic int kw_of(input int k_max);
        return (clog2(k_max + 1) > 0) ? clog2(k_max + 1) : 1;
    endfunction

    function automatic int ridx_w(input int rows);
        return (rows > 1) ? clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/systolic_array_param_pe.sv
// One output-stationary cell: signed MAC into a wrapping accumulator, a/b forwarded one step later.
// Advances only when step is high; clr wins over step and zeroes everything.
module systolic_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    input  logic              clr,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0]  acc_o
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = $signed(a_i) * $signed(b_i);
    assign prod_ext = ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_o   <= '0;
            b_o   <= '0;
            acc_o <= '0;
        end else if (clr) begin
            a_o   <= '0;
            b_o   <= '0;
            acc_o <= '0;
        end else if (step) begin
            a_o   <= a_i;
            b_o   <= b_i;
            acc_o <= acc_o + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_array_param.sv
// ROWS x COLS output-stationary matmul: 1 + k_len + ROWS+COLS-2 cycles to first row, then one row per handshake.
// in_ready stalls the array when in_valid is low; out_ready low holds the current row stable.
module systolic_array_param
    import systolic_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 256,
    localparam int KW    = kw_of(K_MAX),
    localparam int RW    = ridx_w(ROWS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [KW-1:0]         k_len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROWS*DATA_W-1:0] a_in,
    input  logic [COLS*DATA_W-1:0] b_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COLS*ACC_W-1:0] out_row,
    output logic [RW-1:0]         out_row_idx,
    output logic                  out_last,
    output logic                  done
);

    localparam int FLUSH_STEPS = ROWS + COLS - 2;
    localparam int FW          = clog2(ROWS + COLS);
    localparam int FLUSH_LAST  = (FLUSH_STEPS > 0) ? FLUSH_STEPS - 1 : 0;

    if (ACC_W < 2*DATA_W) begin : g_bad_acc
        $error("systolic_array_param: ACC_W must be at least 2*DATA_W");
    end
    if (ROWS < 1 || COLS < 1) begin : g_bad_shape
        $error("systolic_array_param: ROWS and COLS must be at least 1");
    end

    state_t        state, state_nxt;
    logic [KW-1:0] k_reg;
    logic [KW-1:0] beat_cnt;
    logic [FW-1:0] flush_cnt;
    logic [RW-1:0] row_cnt;

    logic start_acc, load_hs, step, last_beat, flush_end, row_hs, last_row;

    assign start_acc = (state == ST_IDLE) && start;
    assign load_hs   = (state == ST_LOAD) && in_valid;
    assign step      = load_hs || (state == ST_FLUSH);
    assign last_beat = load_hs && (beat_cnt == k_reg - KW'(1));
    assign flush_end = (state == ST_FLUSH) && (flush_cnt == FW'(FLUSH_LAST));
    assign row_hs    = (state == ST_DRAIN) && out_ready;
    assign last_row  = (row_cnt == RW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (k_len == '0) ? ST_DRAIN : ST_LOAD;
            ST_LOAD:  if (last_beat) state_nxt = (FLUSH_STEPS == 0) ? ST_DRAIN : ST_FLUSH;
            ST_FLUSH: if (flush_end) state_nxt = ST_DRAIN;
            ST_DRAIN: if (row_hs && last_row) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        in_ready  = (state == ST_LOAD);
        out_valid = (state == ST_DRAIN);
        out_last  = (state == ST_DRAIN) && last_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_cnt   <= '0;
            done      <= 1'b0;
        end else begin
            done <= row_hs && last_row;
            if (start_acc) begin
                k_reg     <= k_len;
                beat_cnt  <= '0;
                flush_cnt <= '0;
                row_cnt   <= '0;
            end else begin
                if (load_hs)             beat_cnt  <= beat_cnt + KW'(1);
                if (state == ST_FLUSH)   flush_cnt <= flush_cnt + FW'(1);
                if (row_hs)              row_cnt   <= last_row ? '0 : row_cnt + RW'(1);
            end
        end
    end

    logic [DATA_W-1:0] a_w   [ROWS][COLS+1];
    logic [DATA_W-1:0] b_w   [ROWS+1][COLS];
    logic [ACC_W-1:0]  acc_w [ROWS][COLS];

    // Lane r of A is delayed r steps so element k meets B[k][c] at PE(r,c) on step k+r+c.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic [DATA_W-1:0] a_head;
        logic              unused_a_edge;
        assign a_head        = (state == ST_LOAD) ? a_in[r*DATA_W +: DATA_W] : '0;
        assign unused_a_edge = ^a_w[r][COLS];
        if (r == 0) begin : g_direct
            assign a_w[r][0] = a_head;
        end else begin : g_delay
            logic [DATA_W-1:0] sr [r];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else if (start_acc) begin
                    for (int i = 0; i < r; i++) sr[i] <= '0;
                end else if (step) begin
                    sr[0] <= a_head;
                    for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
                end
            end
            assign a_w[r][0] = sr[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        logic [DATA_W-1:0] b_head;
        logic              unused_b_edge;
        assign b_head        = (state == ST_LOAD) ? b_in[c*DATA_W +: DATA_W] : '0;
        assign unused_b_edge = ^b_w[ROWS][c];
        if (c == 0) begin : g_direct
            assign b_w[0][c] = b_head;
        end else begin : g_delay
            logic [DATA_W-1:0] sr [c];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else if (start_acc) begin
                    for (int i = 0; i < c; i++) sr[i] <= '0;
                end else if (step) begin
                    sr[0] <= b_head;
                    for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
                end
            end
            assign b_w[0][c] = sr[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            systolic_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk   (clk),
                .rst_n (rst_n),
                .step  (step),
                .clr   (start_acc),
                .a_i   (a_w[r][c]),
                .b_i   (b_w[r][c]),
                .a_o   (a_w[r][c+1]),
                .b_o   (b_w[r+1][c]),
                .acc_o (acc_w[r][c])
            );
        end
    end

    // Accumulators are read in place; the row counter alone selects what is presented.
    always_comb begin
        out_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_cnt == RW'(r)) begin
                for (int c = 0; c < COLS; c++) out_row[c*ACC_W +: ACC_W] = acc_w[r][c];
            end
        end
    end

    assign out_row_idx = row_cnt;

endmodule

// File: tb/tb_systolic_array_param.sv
// Bench for systolic_array_param: a 2x2/ACC_W=16 and an 8x8/ACC_W=32 instance against a matrix-product model.
// Rows are compared against the model on every cycle out_valid is high, including stall cycles.
module tb_systolic_array_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         s_start, s_busy, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_done;
    logic [8:0]   s_k_len;
    logic [15:0]  s_a_in, s_b_in;
    logic [31:0]  s_out_row;
    logic [0:0]   s_out_row_idx;

    logic         l_start, l_busy, l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_out_last, l_done;
    logic [8:0]   l_k_len;
    logic [63:0]  l_a_in, l_b_in;
    logic [255:0] l_out_row;
    logic [2:0]   l_out_row_idx;

    systolic_array_param #(.ROWS(2), .COLS(2), .DATA_W(8), .ACC_W(16), .K_MAX(256)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .k_len(s_k_len), .busy(s_busy),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .a_in(s_a_in), .b_in(s_b_in),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_row(s_out_row),
        .out_row_idx(s_out_row_idx), .out_last(s_out_last), .done(s_done)
    );

    systolic_array_param #(.ROWS(8), .COLS(8), .DATA_W(8), .ACC_W(32), .K_MAX(256)) u_large (
        .clk(clk), .rst_n(rst_n), .start(l_start), .k_len(l_k_len), .busy(l_busy),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .a_in(l_a_in), .b_in(l_b_in),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .out_row(l_out_row),
        .out_row_idx(l_out_row_idx), .out_last(l_out_last), .done(l_done)
    );

    // Model: operand matrices and the expected product C = A*B modulo 2^ACC_W.
    int          ma [8][8];
    int          mb [8][8];
    logic [31:0] exp_c [8][8];

    int          rs = 0, rl = 0;
    int          rows_s = 0, rows_l = 0, done_s_cnt = 0;
    int          last_hs_cyc = 0;
    logic [31:0]  got_s [2];
    logic [255:0] got_l [8];
    logic         lastflag_s [2];

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            rs = 0;
            rl = 0;
        end else begin
            if (s_done) done_s_cnt++;
            if (s_out_valid) begin
                check("s_row", s_out_row, {exp_c[rs][1][15:0], exp_c[rs][0][15:0]});
                check("s_row_idx", s_out_row_idx, rs);
                check("s_last", s_out_last, rs == 1);
                if (s_out_ready) begin
                    got_s[rs]      = s_out_row;
                    lastflag_s[rs] = s_out_last;
                    rows_s++;
                    last_hs_cyc = cyc;
                    rs = (rs + 1) % 2;
                end
            end
            if (l_out_valid) begin
                logic [255:0] el;
                for (int c = 0; c < 8; c++) el[c*32 +: 32] = exp_c[rl][c];
                check("l_row", l_out_row, el);
                check("l_row_idx", l_out_row_idx, rl);
                check("l_last", l_out_last, rl == 7);
                if (l_out_ready) begin
                    got_l[rl] = l_out_row;
                    rows_l++;
                    last_hs_cyc = cyc;
                    rl = (rl + 1) % 8;
                end
            end
        end
    end

    task automatic set_ctl(input bit big, input bit st, input int kl);
        if (big) begin l_start = st; l_k_len = 9'(kl); end
        else     begin s_start = st; s_k_len = 9'(kl); end
    endtask

    task automatic set_vld(input bit big, input bit v);
        if (big) l_in_valid = v;
        else     s_in_valid = v;
    endtask

    task automatic load_beat(input bit big, input int k);
        if (big) begin
            for (int r = 0; r < 8; r++) begin
                l_a_in[r*8 +: 8] = 8'(ma[r][k]);
                l_b_in[r*8 +: 8] = 8'(mb[k][r]);
            end
        end else begin
            for (int r = 0; r < 2; r++) begin
                s_a_in[r*8 +: 8] = 8'(ma[r][k]);
                s_b_in[r*8 +: 8] = 8'(mb[k][r]);
            end
        end
    endtask

    task automatic set_model(input bit big, input int kl);
        longint acc;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                acc = 0;
                for (int k = 0; k < kl; k++) acc += longint'(ma[r][k]) * longint'(mb[k][c]);
                exp_c[r][c] = big ? acc[31:0] : {16'h0, acc[15:0]};
            end
        end
    endtask

    task automatic run_job(input bit big, input int kl, input bit gap, input bit stall, input bit poke);
        int  b, t0, tmo, stalls, done_cyc, nrows;
        bit  hs, seen_done;
        nrows = big ? 8 : 2;
        set_model(big, kl);
        rows_s = 0;
        rows_l = 0;
        @(posedge clk); #1;
        set_ctl(big, 1'b1, kl);
        set_vld(big, kl > 0);
        if (kl > 0) load_beat(big, 0);
        t0 = cyc;
        b = 0;
        tmo = 0;
        if (kl == 0) begin
            @(posedge clk); #1;
            set_ctl(big, 1'b0, kl);
        end
        while (b < kl && tmo < 400) begin
            @(negedge clk);
            hs = big ? (l_in_ready && l_in_valid) : (s_in_ready && s_in_valid);
            @(posedge clk); #1;
            tmo++;
            set_ctl(big, 1'b0, kl);
            if (hs) begin
                b++;
                if (poke && b == 3) set_ctl(big, 1'b1, 3);
                if (b < kl) begin
                    if (gap) begin
                        set_vld(big, 1'b0);
                        @(posedge clk); #1;
                        set_ctl(big, 1'b0, kl);
                    end
                    load_beat(big, b);
                    set_vld(big, 1'b1);
                end else begin
                    set_vld(big, 1'b0);
                end
            end
        end
        check("beats_accepted", b, kl);
        seen_done = 0;
        tmo = 0;
        stalls = 0;
        done_cyc = 0;
        while (!seen_done && tmo < 400) begin
            if (poke && kl == 0 && tmo == 0) set_ctl(big, 1'b1, 5);
            if (stall && big && l_out_valid && l_out_row_idx == 3'd2 && stalls < 3) begin
                l_out_ready = 1'b0;
                stalls++;
            end else begin
                l_out_ready = 1'b1;
            end
            @(negedge clk);
            if (big ? l_done : s_done) begin
                seen_done = 1;
                done_cyc = cyc;
                check("busy_at_done", big ? l_busy : s_busy, 0);
            end else begin
                @(posedge clk); #1;
                tmo++;
                set_ctl(big, 1'b0, kl);
            end
        end
        l_out_ready = 1'b1;
        check("done_seen", seen_done, 1);
        check("rows_emitted", big ? rows_l : rows_s, nrows);
        check("done_after_last_row", done_cyc - last_hs_cyc, 1);
        if (stall) check("stall_cycles", stalls, 3);
        if (!gap && !stall)
            check("job_latency", done_cyc - t0, 1 + nrows + ((kl > 0) ? kl + 2*nrows - 2 : 0));
        @(negedge clk);
        check("done_one_cycle", big ? l_done : s_done, 0);
    endtask

    task automatic clear_mats();
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                ma[r][k] = 0;
                mb[r][k] = 0;
            end
    endtask

    task automatic mats_test1();
        clear_mats();
        ma[0][0] = 3;
        ma[1][0] = -2;
        mb[0][0] = 4;
        mb[0][1] = 5;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        rst_n = 1'b0;
        s_start = 0; s_k_len = 0; s_in_valid = 0; s_a_in = 0; s_b_in = 0; s_out_ready = 1;
        l_start = 0; l_k_len = 0; l_in_valid = 0; l_a_in = 0; l_b_in = 0; l_out_ready = 1;
        clear_mats();
        set_model(1'b0, 0);
        #12;
        check("rst_s_busy", s_busy, 0);
        check("rst_s_in_ready", s_in_ready, 0);
        check("rst_s_out_valid", s_out_valid, 0);
        check("rst_s_out_row", s_out_row, 0);
        check("rst_l_out_row", l_out_row, 0);
        check("rst_l_done", l_done, 0);
        check("rst_l_out_last", l_out_last, 0);
        check("rst_l_row_idx", l_out_row_idx, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 2x2, k=1
        mats_test1();
        run_job(1'b0, 1, 1'b0, 1'b0, 1'b0);
        check("t1_row0", got_s[0], {16'd15, 16'd12});
        check("t1_row1", got_s[1], 32'hFFF6_FFF8);
        check("t1_last_on_row1", lastflag_s[1], 1);
        check("t1_no_last_row0", lastflag_s[0], 0);

        // 8x8 identity times B[k][c]=8k+c
        clear_mats();
        for (int r = 0; r < 8; r++) ma[r][r] = 1;
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < 8; c++) mb[k][c] = 8*k + c;
        run_job(1'b1, 8, 1'b0, 1'b0, 1'b0);
        check("t2_row5_c0", got_l[5][31:0], 40);
        check("t2_row5_c7", got_l[5][255:224], 47);
        check("t2_row7_c7", got_l[7][255:224], 63);

        // Same job with input bubbles, an output stall on row 2 and an ignored start
        got_l[5] = '0;
        run_job(1'b1, 8, 1'b1, 1'b1, 1'b1);
        check("t3_row5_c0", got_l[5][31:0], 40);
        check("t3_row0_c3", got_l[0][127:96], 3);

        // Wrap: four products of 16384 sum to 65536, zero modulo 2^16
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 8; k++) begin
                ma[r][k] = -128;
                mb[k][r] = -128;
            end
        run_job(1'b0, 4, 1'b0, 1'b0, 1'b0);
        check("t4_wrap_row0", got_s[0], 0);
        check("t4_wrap_row1", got_s[1], 0);

        // Reset during FLUSH
        mats_test1();
        rows_s = 0;
        @(posedge clk); #1;
        s_start = 1; s_k_len = 1; s_in_valid = 1;
        load_beat(1'b0, 0);
        @(posedge clk); #1;
        s_start = 0;
        @(posedge clk); #1;
        s_in_valid = 0;
        check("pre_reset_busy", s_busy, 1);
        dcnt = done_s_cnt;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", s_busy, 0);
        check("mid_rst_in_ready", s_in_ready, 0);
        check("mid_rst_out_valid", s_out_valid, 0);
        check("mid_rst_out_last", s_out_last, 0);
        check("mid_rst_done", s_done, 0);
        check("mid_rst_out_row", s_out_row, 0);
        check("mid_rst_row_idx", s_out_row_idx, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("no_done_after_reset", done_s_cnt, dcnt);
        check("no_rows_after_reset", rows_s, 0);
        run_job(1'b0, 1, 1'b0, 1'b0, 1'b0);
        check("t5_row0", got_s[0], {16'd15, 16'd12});
        check("t5_row1", got_s[1], 32'hFFF6_FFF8);

        // k_len = 0 drains zeros; a start during DRAIN is ignored
        run_job(1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("t6_row0_zero", got_s[0], 0);
        check("t6_row1_zero", got_s[1], 0);
        repeat (3) @(negedge clk);
        check("t6_idle_after", s_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
